// File: rtl/phase_defs.sv
`default_nettype none
// ============================================================================
//  Module   : phase_defs (package)
//  Brief    : Machine-phase codes, error codes and tracker FSM states shared
//             by the phase tracker and its watchdog.
//  Revision : 1.0  initial release
// ============================================================================
package phase_defs;

    localparam int PHASE_W = 4;

    localparam logic [PHASE_W-1:0] STATE_INIT    = 4'd0;
    localparam logic [PHASE_W-1:0] STATE_FETCH   = 4'd1;
    localparam logic [PHASE_W-1:0] STATE_DECODE  = 4'd2;
    localparam logic [PHASE_W-1:0] STATE_EXECUTE = 4'd3;
    localparam logic [PHASE_W-1:0] STATE_WRITE   = 4'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;
    localparam logic [1:0] ERR_WDOG    = 2'd3;

    typedef enum logic [1:0] {
        FSM_SYNC  = 2'd0,
        FSM_TRACK = 2'd1,
        FSM_ERROR = 2'd2
    } fsm_t;

    // Successor in the instruction cycle; INIT and illegal codes map to FETCH.
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-1:0] n;
        case (p)
            STATE_FETCH:   n = STATE_DECODE;
            STATE_DECODE:  n = STATE_EXECUTE;
            STATE_EXECUTE: n = STATE_WRITE;
            default:       n = STATE_FETCH;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : phase_watchdog
//  Brief    : Counts consecutive hold cycles of one phase and flags expiry
//             when the count would reach HOLD_MAX.
//  Revision : 1.0  initial release
// ============================================================================
module phase_watchdog #(
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    output logic expire_o
);

    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;

    // Any non-hold cycle (phase entry, sync, error) restarts the count.
    always_comb begin
        hold_cnt_d = 8'd0;
        if (hold_i) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    assign expire_o = hold_i && (hold_cnt_q == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phase_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : phase_tracker
//  Brief    : Consumer of the machine-phase bus: entry strobes, order check,
//             stall watchdog and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module phase_tracker
    import phase_defs::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] state,
    input  logic               err_clr,
    output logic               fetch_stb,
    output logic               decode_stb,
    output logic               exec_stb,
    output logic               write_stb,
    output logic               in_sync,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   retired
);

    logic [PHASE_W-1:0] state_q;
    logic               err_clr_q;
    fsm_t               fsm_q, fsm_d;
    logic [PHASE_W-1:0] prev_q, prev_d;
    logic [3:0]         stb_q, stb_d;
    logic               in_sync_q;
    logic               err_q;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic w_legal;
    logic w_hold;
    logic w_expire;

    assign w_legal = (state_q <= STATE_WRITE);
    assign w_hold  = (fsm_q == FSM_TRACK) && (state_q == prev_q);

    phase_watchdog #(
        .HOLD_MAX (HOLD_MAX)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (w_hold),
        .expire_o (w_expire)
    );

    always_comb begin
        fsm_d      = fsm_q;
        prev_d     = prev_q;
        stb_d      = 4'b0000;
        err_code_d = err_code_q;
        retired_d  = retired_q;

        case (fsm_q)
            FSM_SYNC: begin
                if (!w_legal) begin
                    fsm_d      = FSM_ERROR;
                    err_code_d = ERR_ILLEGAL;
                end else if (state_q == STATE_FETCH) begin
                    fsm_d    = FSM_TRACK;
                    prev_d   = STATE_FETCH;
                    stb_d[0] = 1'b1;
                end
            end

            FSM_TRACK: begin
                if (!w_legal) begin
                    fsm_d      = FSM_ERROR;
                    err_code_d = ERR_ILLEGAL;
                end else if (state_q == prev_q) begin
                    if (w_expire) begin
                        fsm_d      = FSM_ERROR;
                        err_code_d = ERR_WDOG;
                    end
                end else if (state_q == next_phase(prev_q)) begin
                    prev_d = state_q;
                    case (state_q)
                        STATE_FETCH:   stb_d[0] = 1'b1;
                        STATE_DECODE:  stb_d[1] = 1'b1;
                        STATE_EXECUTE: stb_d[2] = 1'b1;
                        STATE_WRITE:   stb_d[3] = 1'b1;
                        default:       stb_d    = 4'b0000;
                    endcase
                    if (prev_q == STATE_WRITE) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                end else begin
                    // Skips, backward steps and a re-INIT all land here.
                    fsm_d      = FSM_ERROR;
                    err_code_d = ERR_ORDER;
                end
            end

            FSM_ERROR: begin
                // A fresh illegal code in the clear cycle keeps the error.
                if (err_clr_q && w_legal) begin
                    fsm_d      = FSM_SYNC;
                    prev_d     = STATE_INIT;
                    err_code_d = ERR_NONE;
                end
            end

            default: begin
                fsm_d = FSM_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STATE_INIT;
            err_clr_q  <= 1'b0;
            fsm_q      <= FSM_SYNC;
            prev_q     <= STATE_INIT;
            stb_q      <= 4'b0000;
            in_sync_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            retired_q  <= '0;
        end else begin
            state_q    <= state;
            err_clr_q  <= err_clr;
            fsm_q      <= fsm_d;
            prev_q     <= prev_d;
            stb_q      <= stb_d;
            in_sync_q  <= (fsm_d == FSM_TRACK);
            err_q      <= (fsm_d == FSM_ERROR);
            err_code_q <= err_code_d;
            retired_q  <= retired_d;
        end
    end

    assign fetch_stb  = stb_q[0];
    assign decode_stb = stb_q[1];
    assign exec_stb   = stb_q[2];
    assign write_stb  = stb_q[3];
    assign in_sync    = in_sync_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign retired    = retired_q;

endmodule
`default_nettype wire
